// File: rtl/gpio_apb_master.sv
// APB3 requester for the GPIO register bank: one single-beat read or write per accepted command.
// Define GPIO_APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module gpio_apb_master #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    if (DATA_W != 32) begin : g_data_w_check
        $error("gpio_apb_master: DATA_W must be 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("gpio_apb_master: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0] state;

`ifdef GPIO_APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign cmd_ready = (state == S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef GPIO_APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        // Unaligned addresses are rejected locally without touching the bus.
                        if (cmd_addr[1:0] != 2'b00) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end else begin
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
`ifdef GPIO_APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
                        state     <= S_RESP;
                    end
`ifdef GPIO_APB_MASTER_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) begin
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
